// File: rtl/memory_data_buffer_if.sv
// Handshake bundle between data memory, the memory data buffer and writeback.
// master = producer/consumer side (memory + writeback), slave = the buffer itself.
interface memory_data_buffer_if #(
    parameter int DATA_SIZE = 32,
    parameter int DEPTH     = 4
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int OFF_W = $clog2(DATA_SIZE / 8);

    logic                 InValid;
    logic                 InReady;
    logic [DATA_SIZE-1:0] WriteData;
    logic [OFF_W-1:0]     ByteOff;
    logic [1:0]           Size;
    logic                 Signed;
    logic                 OutValid;
    logic                 OutReady;
    logic [DATA_SIZE-1:0] ReadData;
    logic [PTR_W:0]       Count;

    modport master (
        output InValid, WriteData, ByteOff, Size, Signed, OutReady,
        input  InReady, OutValid, ReadData, Count
    );

    modport slave (
        input  InValid, WriteData, ByteOff, Size, Signed, OutReady,
        output InReady, OutValid, ReadData, Count
    );
endinterface

// File: rtl/memory_data_buffer.sv
// DEPTH-entry FIFO between data memory and writeback; lane extraction and extension at push.
// Optional same-cycle empty bypass enabled by defining MDB_BYPASS_EN.
module memory_data_buffer #(
    parameter int DATA_SIZE = 32,
    parameter int DEPTH     = 4
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 Flush,
    memory_data_buffer_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int OFF_W = $clog2(DATA_SIZE / 8);
    localparam int BIT_W = $clog2(DATA_SIZE);
    localparam int LB_W  = BIT_W + 1;

    logic [DATA_SIZE-1:0] mem [DEPTH];
    logic [PTR_W-1:0]     wrPtr;
    logic [PTR_W-1:0]     rdPtr;
    logic [CNT_W-1:0]     count;

    logic [1:0]           effSize;
    logic [OFF_W-1:0]     laneOff;
    logic [DATA_SIZE-1:0] shifted;
    logic [LB_W-1:0]      laneBits;
    logic [LB_W-1:0]      topBit;
    logic                 fullWidth;
    logic [DATA_SIZE-1:0] laneMask;
    logic                 signBit;
    logic [DATA_SIZE-1:0] extended;

    logic                 inReady;
    logic                 storedValid;
    logic                 bypassFire;
    logic                 push;
    logic                 pop;

    // Align the lane down to the access size, then mask and fill the upper bits with the sign or zeros.
    always_comb begin
        effSize = bus.Size;
        if (DATA_SIZE == 32 && bus.Size == 2'b11) effSize = 2'b10;
        laneOff   = bus.ByteOff & ~((OFF_W'(1) << effSize) - OFF_W'(1));
        shifted   = bus.WriteData >> {laneOff, 3'b000};
        laneBits  = LB_W'(8) << effSize;
        topBit    = laneBits - LB_W'(1);
        fullWidth = (laneBits == LB_W'(DATA_SIZE));
        laneMask  = fullWidth ? '1 : ((DATA_SIZE'(1) << laneBits) - DATA_SIZE'(1));
        signBit   = bus.Signed & shifted[topBit[BIT_W-1:0]];
        extended  = (shifted & laneMask) | (signBit ? ~laneMask : '0);
    end

    assign storedValid = (count != '0);
    assign inReady     = (count != CNT_W'(DEPTH));

`ifdef MDB_BYPASS_EN
    assign bypassFire = (count == '0) & bus.InValid & bus.OutReady & ~Flush & ~Rst;
`else
    assign bypassFire = 1'b0;
`endif

    // A bypassed word is consumed directly, so it never occupies a slot.
    assign push = bus.InValid & inReady & ~bypassFire;
    assign pop  = storedValid & bus.OutReady;

    always_comb begin
        bus.InReady  = inReady;
        bus.Count    = count;
        bus.OutValid = storedValid;
        bus.ReadData = storedValid ? mem[rdPtr] : '0;
        if (bypassFire) begin
            bus.OutValid = 1'b1;
            bus.ReadData = extended;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge Clk) begin
        if (Rst || Flush) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (push) wrPtr <= wrPtr + PTR_W'(1);
            if (pop)  rdPtr <= rdPtr + PTR_W'(1);
            if (push && !pop)      count <= count + CNT_W'(1);
            else if (pop && !push) count <= count - CNT_W'(1);
        end
    end

    // Slot contents need no reset; a stray write during Rst/Flush lands in a slot that is now free.
    always_ff @(posedge Clk) begin
        if (push) mem[wrPtr] <= extended;
    end
endmodule

// File: tb/tb_memory_data_buffer.sv
// Scoreboard bench for memory_data_buffer: stimulus queues expected words, a monitor pops and compares.
module tb_memory_data_buffer;
    localparam int DATA_SIZE = 32;
    localparam int DEPTH     = 4;

    logic Clk = 1'b0;
    logic Rst;
    logic Flush;

    int compared   = 0;
    int mismatched = 0;
    logic [31:0] expQ [$];

    memory_data_buffer_if #(.DATA_SIZE(DATA_SIZE), .DEPTH(DEPTH)) bus ();

    memory_data_buffer #(.DATA_SIZE(DATA_SIZE), .DEPTH(DEPTH)) dut (
        .Clk   (Clk),
        .Rst   (Rst),
        .Flush (Flush),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Reference extraction: pick S bytes from the aligned lane, then sign/zero extend arithmetically.
    function automatic logic [31:0] refExtract(input logic [31:0] word, input int off, input int size, input bit sgn);
        int bytes;
        int lane;
        longint unsigned raw;
        longint value;
        bytes = 1 << size;
        if (bytes > 4) bytes = 4;
        lane  = (off / bytes) * bytes;
        raw   = {32'b0, word};
        raw   = (raw >> (8 * lane)) % (64'd1 << (8 * bytes));
        value = longint'(raw);
        if (sgn && raw >= (64'd1 << (8 * bytes - 1))) value = value - (longint'(1) << (8 * bytes));
        return value[31:0];
    endfunction

    // Drive one cycle of inputs; the expected word is queued only if the push will really fire.
    task automatic applyStimulus(input bit valid, input logic [31:0] data, input logic [1:0] off,
                                 input logic [1:0] size, input bit sgn, input bit ready,
                                 input bit flush, input logic [31:0] expVal);
        bus.InValid   = valid;
        bus.WriteData = data;
        bus.ByteOff   = off;
        bus.Size      = size;
        bus.Signed    = sgn;
        bus.OutReady  = ready;
        Flush         = flush;
        @(negedge Clk);
        if (flush) expQ.delete();
        else if (valid && bus.InReady === 1'b1) expQ.push_back(expVal);
        @(posedge Clk);
        #1;
    endtask

    always begin
        @(negedge Clk);
        #1;
        if (Rst === 1'b0 && bus.OutValid === 1'b1 && bus.OutReady === 1'b1) begin
            if (expQ.size() == 0) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL unexpectedOutput: got %h, expected no output", bus.ReadData);
            end else begin
                checkOutput("readData", bus.ReadData, expQ.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] data;
        logic [1:0]  off;
        logic [1:0]  size;
        bit          valid;
        bit          ready;
        bit          sgn;
        bit          flush;

        Rst = 1'b1;
        Flush = 1'b0;
        bus.InValid = 1'b0;
        bus.WriteData = '0;
        bus.ByteOff = '0;
        bus.Size = '0;
        bus.Signed = 1'b0;
        bus.OutReady = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        checkOutput("resetOutValid", 32'(bus.OutValid), 32'd0);
        checkOutput("resetInReady", 32'(bus.InReady), 32'd1);
        checkOutput("resetCount", 32'(bus.Count), 32'd0);
        checkOutput("resetReadData", bus.ReadData, 32'd0);
        Rst = 1'b0;

        applyStimulus(1, 32'h80F1_7F22, 2'd2, 2'b00, 1, 1, 0, 32'hFFFF_FFF1);
        applyStimulus(1, 32'h80F1_7F22, 2'd1, 2'b00, 0, 1, 0, 32'h0000_007F);
        applyStimulus(1, 32'h80F1_7F22, 2'd2, 2'b01, 1, 1, 0, 32'hFFFF_80F1);
        applyStimulus(1, 32'h80F1_7F22, 2'd3, 2'b01, 0, 1, 0, 32'h0000_80F1);
        applyStimulus(1, 32'h80F1_7F22, 2'd3, 2'b11, 1, 1, 0, 32'h80F1_7F22);
        repeat (2) applyStimulus(0, 32'd0, 2'd0, 2'b10, 0, 1, 0, 32'd0);

        bus.InValid = 1'b1;
        bus.WriteData = 32'h1234_5678;
        bus.ByteOff = 2'd0;
        bus.Size = 2'b10;
        bus.Signed = 1'b0;
        bus.OutReady = 1'b1;
        @(negedge Clk);
`ifdef MDB_BYPASS_EN
        checkOutput("bypassValid", 32'(bus.OutValid), 32'd1);
        checkOutput("bypassData", bus.ReadData, 32'h1234_5678);
`else
        checkOutput("latencyValid", 32'(bus.OutValid), 32'd0);
`endif
        if (bus.InReady === 1'b1) expQ.push_back(32'h1234_5678);
        @(posedge Clk);
        #1;
        bus.InValid = 1'b0;
`ifdef MDB_BYPASS_EN
        checkOutput("bypassCount", 32'(bus.Count), 32'd0);
`else
        checkOutput("latencyCount", 32'(bus.Count), 32'd1);
        checkOutput("latencyData", bus.ReadData, 32'h1234_5678);
`endif
        applyStimulus(0, 32'd0, 2'd0, 2'b10, 0, 1, 0, 32'd0);

        for (int i = 1; i <= 4; i++) applyStimulus(1, 32'(i), 2'd0, 2'b10, 0, 0, 0, 32'(i));
        checkOutput("fullCount", 32'(bus.Count), 32'd4);
        checkOutput("fullInReady", 32'(bus.InReady), 32'd0);
        applyStimulus(1, 32'd5, 2'd0, 2'b10, 0, 0, 0, 32'd5);
        checkOutput("fullRejectCount", 32'(bus.Count), 32'd4);
        for (int i = 3; i >= 0; i--) begin
            applyStimulus(0, 32'd0, 2'd0, 2'b10, 0, 1, 0, 32'd0);
            checkOutput("drainCount", 32'(bus.Count), 32'(i));
        end

        applyStimulus(1, 32'd10, 2'd0, 2'b10, 0, 0, 0, 32'd10);
        applyStimulus(1, 32'd11, 2'd0, 2'b10, 0, 0, 0, 32'd11);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1, 32'(20 + i), 2'd0, 2'b10, 0, 1, 0, 32'(20 + i));
            checkOutput("steadyCount", 32'(bus.Count), 32'd2);
        end
        repeat (2) applyStimulus(0, 32'd0, 2'd0, 2'b10, 0, 1, 0, 32'd0);

        for (int i = 0; i < 3; i++) applyStimulus(1, 32'(30 + i), 2'd0, 2'b10, 0, 0, 0, 32'(30 + i));
        applyStimulus(1, 32'd99, 2'd0, 2'b10, 0, 0, 1, 32'd99);
        checkOutput("flushCount", 32'(bus.Count), 32'd0);
        checkOutput("flushOutValid", 32'(bus.OutValid), 32'd0);
        checkOutput("flushReadData", bus.ReadData, 32'd0);
        repeat (2) applyStimulus(0, 32'd0, 2'd0, 2'b10, 0, 1, 0, 32'd0);

        for (int i = 0; i < 400; i++) begin
            checkOutput("randomCount", 32'(bus.Count), 32'(expQ.size()));
            flush = ($urandom_range(0, 31) == 0);
            valid = 1'($urandom_range(0, 1));
            ready = flush ? 1'b0 : 1'($urandom_range(0, 1));
            data  = $urandom;
            off   = 2'($urandom_range(0, 3));
            size  = 2'($urandom_range(0, 3));
            sgn   = 1'($urandom_range(0, 1));
            applyStimulus(valid, data, off, size, sgn, ready, flush, refExtract(data, int'(off), int'(size), sgn));
        end

        for (int i = 0; i < 20 && expQ.size() != 0; i++) applyStimulus(0, 32'd0, 2'd0, 2'b10, 0, 1, 0, 32'd0);
        checkOutput("drainQueue", 32'(expQ.size()), 32'd0);
        checkOutput("finalCount", 32'(bus.Count), 32'd0);
        checkOutput("finalOutValid", 32'(bus.OutValid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
